// File: rtl/mm_sched_ctrl_if.sv
// mm_sched_ctrl_if: element input, operand-buffer write, MAC control and result
// signals of the matrix-multiply scheduler.
interface mm_sched_ctrl_if #(
  parameter int unsigned MAXD = 4
);
  localparam int unsigned IW = (MAXD > 1) ? $clog2(MAXD) : 1;

  logic          in_valid;
  logic          col_end;
  logic          row_end;
  logic          busy;
  logic          wr_en;
  logic          wr_sel;
  logic [IW-1:0] wr_row;
  logic [IW-1:0] wr_col;
  logic          mac_clr;
  logic          mac_en;
  logic [IW-1:0] rd_i;
  logic [IW-1:0] rd_k;
  logic [IW-1:0] rd_j;
  logic          res_valid;
  logic          is_legal;
  logic          change_row;
  logic [1:0]    ep;

  modport master (
    output in_valid, col_end, row_end,
    input  busy, wr_en, wr_sel, wr_row, wr_col, mac_clr, mac_en,
    input  rd_i, rd_k, rd_j, res_valid, is_legal, change_row, ep
  );

  modport slave (
    input  in_valid, col_end, row_end,
    output busy, wr_en, wr_sel, wr_row, wr_col, mac_clr, mac_en,
    output rd_i, rd_k, rd_j, res_valid, is_legal, change_row, ep
  );
endinterface

// File: rtl/mm_sched_ctrl.sv
// mm_sched_ctrl: loads matrices A and B element by element, checks their shapes,
// then sequences the MAC over every output element of A*B.
module mm_sched_ctrl #(
  parameter int unsigned MAXD = 4
) (
  input  logic           clk,
  input  logic           rst,
  mm_sched_ctrl_if.slave bus
);
  localparam int unsigned IW = (MAXD > 1) ? $clog2(MAXD) : 1;
  // Counters must hold MAXD+1 so oversize shapes are still visible.
  localparam int unsigned CW = $clog2(MAXD + 2);
  localparam logic [CW-1:0] MAX_C = CW'(MAXD);

  typedef enum logic [2:0] {
    LOAD_A, LOAD_B, CHECK, MUL, EMIT, REPORT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] r_cnt, c_cnt, cols0;
  logic [CW-1:0] cols_a, rows_a, cols_b, rows_b;
  logic          ill_cur, ill_a, ill_b;
  logic [IW-1:0] i_idx, j_idx, k_idx;
  logic          busy_q;
  logic [1:0]    ep_q;

  logic          loading, accept, elem_ill;
  logic          last_i, last_j, last_k;
  logic [CW-1:0] row_len, mat_cols, mat_rows, r_inc, c_inc;

  // Element acceptance and shape bookkeeping for the matrix being loaded.
  always_comb begin
    loading  = (state == LOAD_A) || (state == LOAD_B);
    accept   = rst && loading && !busy_q && bus.in_valid;
    row_len  = c_cnt + CW'(1);
    r_inc    = (r_cnt == MAX_C) ? r_cnt : r_cnt + CW'(1);
    c_inc    = (c_cnt == MAX_C) ? c_cnt : c_cnt + CW'(1);
    mat_cols = (r_cnt == '0) ? row_len : cols0;
    mat_rows = r_cnt + CW'(1);
    elem_ill = (c_cnt == MAX_C) || (r_cnt == MAX_C) ||
               (bus.row_end && !bus.col_end) ||
               (bus.col_end && (r_cnt != '0) && (row_len != cols0));
    last_k   = (CW'(k_idx) == cols_a - CW'(1));
    last_j   = (CW'(j_idx) == cols_b - CW'(1));
    last_i   = (CW'(i_idx) == rows_a - CW'(1));
  end

  // Operand-buffer write strobe; indices saturate at MAXD-1.
  always_comb begin
    bus.wr_en  = accept && (c_cnt < MAX_C) && (r_cnt < MAX_C);
    bus.wr_sel = (state == LOAD_B);
    bus.wr_row = (r_cnt < MAX_C) ? IW'(r_cnt) : IW'(MAXD - 1);
    bus.wr_col = (c_cnt < MAX_C) ? IW'(c_cnt) : IW'(MAXD - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD_A;
    else      state <= state_nx;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nx       = state;
    bus.mac_en     = 1'b0;
    bus.mac_clr    = 1'b0;
    bus.rd_i       = '0;
    bus.rd_k       = '0;
    bus.rd_j       = '0;
    bus.res_valid  = 1'b0;
    bus.is_legal   = 1'b0;
    bus.change_row = 1'b0;
    case (state)
      LOAD_A: if (accept && bus.row_end) state_nx = LOAD_B;
      LOAD_B: if (accept && bus.row_end) state_nx = CHECK;
      CHECK: begin
        if (ill_a || ill_b || (cols_a != rows_b)) state_nx = REPORT;
        else                                      state_nx = MUL;
      end
      MUL: begin
        bus.mac_en  = 1'b1;
        bus.mac_clr = (k_idx == '0);
        bus.rd_i    = i_idx;
        bus.rd_k    = k_idx;
        bus.rd_j    = j_idx;
        if (last_k) state_nx = EMIT;
      end
      EMIT: begin
        bus.res_valid  = 1'b1;
        bus.is_legal   = 1'b1;
        bus.change_row = last_j;
        if (last_j && last_i) state_nx = LOAD_A;
        else                  state_nx = MUL;
      end
      REPORT: begin
        bus.res_valid = 1'b1;
        state_nx      = LOAD_A;
      end
      default: state_nx = LOAD_A;
    endcase
  end

  // busy covers CHECK through the last result; ep holds until the next CHECK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      ep_q   <= 2'b00;
    end else begin
      busy_q <= state_nx inside {CHECK, MUL, EMIT, REPORT};
      if (state == CHECK) ep_q <= {ill_b, ill_a};
    end
  end

  assign bus.busy = busy_q;
  assign bus.ep   = ep_q;

  // Shape capture during load, output-index walk during multiply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0; c_cnt <= '0; cols0 <= '0; ill_cur <= 1'b0;
      cols_a <= '0; rows_a <= '0; ill_a <= 1'b0;
      cols_b <= '0; rows_b <= '0; ill_b <= 1'b0;
      i_idx <= '0; j_idx <= '0; k_idx <= '0;
    end else if ((state != LOAD_A) && (state_nx == LOAD_A)) begin
      r_cnt <= '0; c_cnt <= '0; cols0 <= '0; ill_cur <= 1'b0;
      cols_a <= '0; rows_a <= '0; ill_a <= 1'b0;
      cols_b <= '0; rows_b <= '0; ill_b <= 1'b0;
      i_idx <= '0; j_idx <= '0; k_idx <= '0;
    end else begin
      case (state)
        LOAD_A, LOAD_B: begin
          if (accept) begin
            if (bus.row_end) begin
              r_cnt   <= '0;
              c_cnt   <= '0;
              cols0   <= '0;
              ill_cur <= 1'b0;
              if (state == LOAD_A) begin
                cols_a <= mat_cols;
                rows_a <= mat_rows;
                ill_a  <= ill_cur || elem_ill;
              end else begin
                cols_b <= mat_cols;
                rows_b <= mat_rows;
                ill_b  <= ill_cur || elem_ill;
              end
            end else if (bus.col_end) begin
              c_cnt   <= '0;
              r_cnt   <= r_inc;
              ill_cur <= ill_cur || elem_ill;
              if (r_cnt == '0) cols0 <= row_len;
            end else begin
              c_cnt   <= c_inc;
              ill_cur <= ill_cur || elem_ill;
            end
          end
        end
        CHECK: begin
          i_idx <= '0;
          j_idx <= '0;
          k_idx <= '0;
        end
        MUL: k_idx <= last_k ? '0 : k_idx + IW'(1);
        EMIT: begin
          if (last_j) begin
            j_idx <= '0;
            i_idx <= i_idx + IW'(1);
          end else begin
            j_idx <= j_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_sched_ctrl.sv
// tb_mm_sched_ctrl: scoreboard bench for mm_sched_ctrl; expected results are
// queued when matrices are fed and popped on every res_valid.
module tb_mm_sched_ctrl;
  typedef struct packed {
    logic       legal;
    logic       crow;
    logic [1:0] ep;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  mm_sched_ctrl_if #(.MAXD(4)) bus ();
  mm_sched_ctrl #(.MAXD(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  res_t exp_q[$];
  int   res_cyc[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   n_res, n_clr, n_mac, n_wr, wr_busy, check_cyc;
  logic s_busy, busy_prev, prev_res, busy_after_res;

  // One clock: sample at negedge, score any result, return at posedge+1.
  task automatic tick();
    res_t got, want;
    @(negedge clk);
    cyc++;
    s_busy = bus.busy;
    if (s_busy && !busy_prev) check_cyc = cyc;
    if (prev_res) busy_after_res = s_busy;
    prev_res  = bus.res_valid;
    busy_prev = s_busy;
    if (bus.mac_en)  n_mac++;
    if (bus.mac_clr) n_clr++;
    if (bus.wr_en) begin
      n_wr++;
      if (s_busy) wr_busy++;
    end
    if (bus.res_valid) begin
      n_res++;
      res_cyc.push_back(cyc);
      got = {bus.is_legal, bus.change_row, bus.ep};
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected cycle %0d got legal/crow/ep=%b none expected", cyc, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want)
          $display("FAIL sb_result cycle %0d got legal/crow/ep=%b want %b", cyc, got, want);
        else passed++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.col_end  = 1'b0;
    bus.row_end  = 1'b0;
  endtask

  task automatic clear_stats();
    n_res = 0; n_clr = 0; n_mac = 0; n_wr = 0; wr_busy = 0; check_cyc = 0;
    busy_after_res = 1'b1;
    res_cyc.delete();
  endtask

  task automatic feed_row(input int len, input bit ce, input bit re);
    for (int e = 0; e < len; e++) begin
      bus.in_valid = 1'b1;
      bus.col_end  = ce && (e == len - 1);
      bus.row_end  = re && (e == len - 1);
      tick();
    end
    idle_inputs();
  endtask

  task automatic feed_mat(input int rows, input int cols);
    for (int r = 0; r < rows; r++) feed_row(cols, 1'b1, r == rows - 1);
  endtask

  task automatic push_mul(input int rows_a, input int cols_b);
    res_t e;
    for (int i = 0; i < rows_a; i++)
      for (int j = 0; j < cols_b; j++) begin
        e = {1'b1, 1'(j == cols_b - 1), 2'b00};
        exp_q.push_back(e);
      end
  endtask

  // Run until busy has risen and fallen; optionally poke inputs while busy.
  task automatic wait_idle(input int budget, input bit poke);
    bit saw = 1'b0;
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      if (poke) begin
        bus.in_valid = bus.busy && (cyc % 3 == 0);
        bus.col_end  = bus.in_valid;
        bus.row_end  = bus.in_valid;
      end
      tick();
      if (s_busy) saw = 1'b1;
      else if (saw) done = 1'b1;
    end
    idle_inputs();
    total++;
    if (!done) $display("FAIL wait_idle timeout after %0d cycles, busy seen=%b", budget, saw);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    tick();
    total++;
    if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", bus.wr_en); else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++;
    if (bus.ep !== 2'b00) $display("FAIL reset_ep got %b want 00", bus.ep); else passed++;
    total++;
    if ({bus.mac_en, bus.mac_clr, bus.res_valid, bus.is_legal, bus.change_row} !== 5'b0)
      $display("FAIL reset_strobes got %b want 00000",
               {bus.mac_en, bus.mac_clr, bus.res_valid, bus.is_legal, bus.change_row});
    else passed++;
    idle_inputs();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_multiply();
    clear_stats();
    push_mul(2, 2);
    feed_mat(2, 3);
    feed_mat(3, 2);
    wait_idle(100, 1'b0);
    total++;
    if (n_wr !== 12) $display("FAIL mul_wr_count got %0d want 12", n_wr); else passed++;
    total++;
    if (n_res !== 4) $display("FAIL mul_res_count got %0d want 4", n_res); else passed++;
    total++;
    if (n_clr !== 4) $display("FAIL mul_clr_count got %0d want 4", n_clr); else passed++;
    total++;
    if (n_mac !== 12) $display("FAIL mul_mac_count got %0d want 12", n_mac); else passed++;
    total++;
    if (bus.ep !== 2'b00) $display("FAIL mul_ep got %b want 00", bus.ep); else passed++;
    total++;
    if (res_cyc.size() == 0 || res_cyc[0] !== check_cyc + 4)
      $display("FAIL mul_first_latency got %0d want %0d", (res_cyc.size() > 0) ? res_cyc[0] : -1, check_cyc + 4);
    else passed++;
    for (int i = 1; i < res_cyc.size(); i++) begin
      total++;
      if (res_cyc[i] - res_cyc[i-1] !== 4)
        $display("FAIL mul_gap_%0d got %0d want 4", i, res_cyc[i] - res_cyc[i-1]);
      else passed++;
    end
    total++;
    if (exp_q.size() !== 0) $display("FAIL mul_sb_left got %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_illegal_a();
    clear_stats();
    exp_q.push_back({1'b0, 1'b0, 2'b01});
    feed_row(3, 1'b1, 1'b0);
    feed_row(2, 1'b1, 1'b1);
    feed_mat(3, 2);
    wait_idle(50, 1'b0);
    total++;
    if (n_res !== 1) $display("FAIL illa_res_count got %0d want 1", n_res); else passed++;
    total++;
    if (n_mac !== 0) $display("FAIL illa_mac_count got %0d want 0", n_mac); else passed++;
    total++;
    if (bus.ep !== 2'b01) $display("FAIL illa_ep got %b want 01", bus.ep); else passed++;
    total++;
    if (res_cyc.size() == 0 || res_cyc[0] !== check_cyc + 1)
      $display("FAIL illa_report_latency got %0d want %0d", (res_cyc.size() > 0) ? res_cyc[0] : -1, check_cyc + 1);
    else passed++;
  endtask

  task automatic test_both_illegal();
    clear_stats();
    exp_q.push_back({1'b0, 1'b0, 2'b11});
    feed_row(5, 1'b1, 1'b1);
    feed_row(2, 1'b0, 1'b1);
    wait_idle(50, 1'b0);
    total++;
    if (n_wr !== 6) $display("FAIL both_wr_count got %0d want 6", n_wr); else passed++;
    total++;
    if (n_res !== 1) $display("FAIL both_res_count got %0d want 1", n_res); else passed++;
    total++;
    if (bus.ep !== 2'b11) $display("FAIL both_ep got %b want 11", bus.ep); else passed++;
    total++;
    if (n_mac !== 0) $display("FAIL both_mac_count got %0d want 0", n_mac); else passed++;
  endtask

  task automatic test_shape_mismatch();
    clear_stats();
    exp_q.push_back({1'b0, 1'b0, 2'b00});
    feed_mat(2, 3);
    feed_mat(2, 2);
    wait_idle(50, 1'b0);
    total++;
    if (n_res !== 1) $display("FAIL shape_res_count got %0d want 1", n_res); else passed++;
    total++;
    if (n_mac !== 0) $display("FAIL shape_mac_count got %0d want 0", n_mac); else passed++;
    total++;
    if (bus.ep !== 2'b00) $display("FAIL shape_ep got %b want 00", bus.ep); else passed++;
  endtask

  task automatic test_back_to_back();
    clear_stats();
    push_mul(4, 4);
    feed_mat(4, 4);
    feed_mat(4, 4);
    wait_idle(300, 1'b1);
    total++;
    if (n_res !== 16) $display("FAIL b2b_res_count got %0d want 16", n_res); else passed++;
    total++;
    if (res_cyc.size() == 0 || res_cyc[res_cyc.size()-1] !== check_cyc + 80)
      $display("FAIL b2b_last_latency got %0d want %0d",
               (res_cyc.size() > 0) ? res_cyc[res_cyc.size()-1] : -1, check_cyc + 80);
    else passed++;
    total++;
    if (busy_after_res !== 1'b0) $display("FAIL b2b_busy_after got %b want 0", busy_after_res); else passed++;
    total++;
    if (n_wr !== 32) $display("FAIL b2b_wr_count got %0d want 32", n_wr); else passed++;
    total++;
    if (wr_busy !== 0) $display("FAIL b2b_wr_while_busy got %0d want 0", wr_busy); else passed++;
    total++;
    if (n_clr !== 16) $display("FAIL b2b_clr_count got %0d want 16", n_clr); else passed++;
  endtask

  task automatic test_reset_mid_mul();
    int n = 0;
    clear_stats();
    push_mul(2, 2);
    feed_mat(2, 3);
    feed_mat(3, 2);
    while (n_mac < 2 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if ({bus.mac_en, bus.rd_k} !== 3'b110)
      $display("FAIL rmid_in_third_mul got mac_en/rd_k=%b want 110", {bus.mac_en, bus.rd_k});
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({bus.mac_en, bus.mac_clr, bus.res_valid, bus.is_legal, bus.change_row,
         bus.rd_i, bus.rd_k, bus.rd_j} !== 11'b0)
      $display("FAIL rmid_outputs got %b want 0",
               {bus.mac_en, bus.mac_clr, bus.res_valid, bus.is_legal, bus.change_row,
                bus.rd_i, bus.rd_k, bus.rd_j});
    else passed++;
    total++;
    if ({bus.busy, bus.ep} !== 3'b000)
      $display("FAIL rmid_busy_ep got %b want 000", {bus.busy, bus.ep});
    else passed++;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    clear_stats();
    exp_q.push_back({1'b1, 1'b1, 2'b00});
    feed_mat(1, 1);
    feed_mat(1, 1);
    wait_idle(50, 1'b0);
    total++;
    if (n_res !== 1) $display("FAIL one_res_count got %0d want 1", n_res); else passed++;
    total++;
    if (res_cyc.size() == 0 || res_cyc[0] !== check_cyc + 2)
      $display("FAIL one_latency got %0d want %0d", (res_cyc.size() > 0) ? res_cyc[0] : -1, check_cyc + 2);
    else passed++;
    total++;
    if (n_clr !== 1) $display("FAIL one_clr_count got %0d want 1", n_clr); else passed++;
    total++;
    if (n_wr !== 2) $display("FAIL one_wr_count got %0d want 2", n_wr); else passed++;
  endtask

  initial begin
    busy_prev = 1'b0;
    prev_res  = 1'b0;
    idle_inputs();
    clear_stats();
    test_reset();
    test_multiply();
    test_illegal_a();
    test_both_illegal();
    test_shape_mismatch();
    test_back_to_back();
    test_reset_mid_mul();
    total++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover got %0d want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mm_sched_ctrl.md
MM_SCHED_CTRL -- requirements
Module: mm_sched_ctrl

Interface
REQ-001 SHALL have parameter MAXD, default 4, meaning maximum rows or columns per matrix; index ports are 2 bits wide.
REQ-002 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  element present this cycle.
REQ-005 SHALL have port: col_end  input  1  last element of the current row.
REQ-006 SHALL have port: row_end  input  1  last element of the current matrix.
REQ-007 SHALL have port: busy  output  1  element inputs ignored while high.
REQ-008 SHALL have ports: wr_en  output  1; wr_sel  output  1 (0=A, 1=B); wr_row, wr_col  output  2 each; together these are the operand-buffer write strobe and address.
REQ-009 SHALL have ports: mac_clr, mac_en  output  1 each  MAC accumulator clear and enable.
REQ-010 SHALL have ports: rd_i, rd_k, rd_j  output  2 each  operand read indices for A[i][k] and B[k][j].
REQ-011 SHALL have ports: res_valid  output  1; is_legal  output  1; change_row  output  1; ep  output  2 (ep[0]=A illegal, ep[1]=B illegal).

Function
REQ-012 SHALL implement FSM states LOAD_A, LOAD_B, CHECK, MUL, EMIT and REPORT, and SHALL leave reset in LOAD_A.
REQ-013 SHALL accept an element only when in_valid=1 and busy=0; col_end and row_end SHALL be sampled only with an accepted element.
REQ-014 SHALL drive wr_en, wr_row and wr_col combinationally from the accepted element and the current row/column counters, with wr_sel=0 in LOAD_A and 1 in LOAD_B.
REQ-015 SHALL take the width of row 0 (column counter + 1 at col_end) as the matrix column count, and SHALL latch the matrix row count at row_end.
REQ-016 SHALL mark the matrix illegal on any of: a later row length differing from row 0; a column count exceeding MAXD; a row count exceeding MAXD; row_end without col_end.
REQ-017 SHALL suppress wr_en for any element whose column or row index is at or beyond MAXD, and the indices SHALL saturate rather than wrap.
REQ-018 SHALL move LOAD_A->LOAD_B on an accepted row_end, and LOAD_B->CHECK on an accepted row_end; busy SHALL be registered and high from the cycle after B's row_end until the return to LOAD_A.
REQ-019 SHALL, in CHECK (one cycle), register ep={B_illegal, A_illegal}, then go to REPORT if ep!=0 or colsA!=rowsB, otherwise go to MUL with i=j=k=0.
REQ-020 SHALL, in MUL, drive mac_en=1 and rd_i=i, rd_k=k, rd_j=j for colsA cycles with k=0..colsA-1, assert mac_clr only at k=0, and then go to EMIT.
REQ-021 SHALL, in EMIT (one cycle), drive res_valid=1 and is_legal=1, with change_row=1 iff j==colsB-1; mac_en=0.
REQ-022 SHALL, after EMIT, advance (i,j) row-major and return to MUL, or go to LOAD_A after (rowsA-1, colsB-1); each output therefore costs colsA+1 cycles.
REQ-023 SHALL, in REPORT (one cycle), drive res_valid=1, is_legal=0 and change_row=0, then go to LOAD_A.
REQ-024 SHALL hold ep from CHECK until the next CHECK; res_valid, is_legal, change_row, mac_en and mac_clr SHALL be 0 outside EMIT, REPORT and MUL respectively.
REQ-025 SHALL clear all counters, shape registers and illegal flags on entry to LOAD_A.
REQ-026 SHALL not signal overflow; arithmetic width and overflow detection belong to the datapath.

Reset
REQ-027 SHALL, while rst=0, force state LOAD_A, busy=0, ep=00, and all strobes, indices and counters to 0, including mid-MUL; the first job after release SHALL run correctly.

Verification
REQ-028 SHALL cover: A 2x3, B 3x2 legal -> ep=00; 4 res_valid pulses 4 cycles apart; change_row=1 on pulses 2 and 4; mac_clr once per output.
REQ-029 SHALL cover: A rows of lengths 3 then 2 -> ep=01; exactly one res_valid with is_legal=0; no mac_en.
REQ-030 SHALL cover: A with a 5-element row and B with row_end without col_end -> ep=11; one REPORT pulse.
REQ-031 SHALL cover: A 2x3, B 2x2 (both legal) -> ep=00; one res_valid with is_legal=0.
REQ-032 SHALL cover: A 4x4, B 4x4 -> 16 outputs in 80 cycles after CHECK; busy=0 the cycle after the last EMIT; in_valid pulses during busy cause no wr_en.
REQ-033 SHALL cover: rst=0 asserted during the 3rd MUL -> outputs 0 immediately; a following 1x1 by 1x1 job -> one output 2 cycles after CHECK with change_row=1.
